imem_boot_loader: RTL and testbench

//  Boot-time program loader upstream of the PikaRISC core's instruction memory.
//  - Receives a framed byte stream and assembles 32-bit words.
//  - Writes the words into the instruction memory through a dedicated write port.
//  - Holds the core in reset until a complete frame with a valid checksum has loaded.
//  - Frame: MAGIC, LEN_LO, LEN_HI, LEN x {B0,B1,B2,B3} (little-endian words), CSUM.

---
 rtl/imem_boot_loader_if.sv | 42 ++++
 rtl/imem_boot_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Boot-loader bus bundle: byte stream in, instruction-memory write port and
// core-control status out.
//   rx_valid/rx_data/rx_ready  byte stream handshake (transfer = valid & ready)
//   imem_wr_en/addr/data       one-cycle write strobe into instruction memory
//   cpu_reset                  core reset, high until a frame loads cleanly
//   load_done/load_error       sticky completion / failure flags
// master: the stream source / system side.  slave: the loader.
interface imem_boot_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_wr_en,
        input  imem_wr_addr,
        input  imem_wr_data,
        input  cpu_reset,
        input  load_done,
        input  load_error
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_wr_en,
        output imem_wr_addr,
        output imem_wr_data,
        output cpu_reset,
        output load_done,
        output load_error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot-time program loader for the PikaRISC instruction memory.
// Accepts a framed byte stream
//     MAGIC, LEN_LO, LEN_HI, LEN x {B0,B1,B2,B3}, CSUM
// assembles little-endian 32-bit words, writes them to imem at
// BASE_ADDR + n*ADDR_STEP, and releases the core from reset only after the
// XOR checksum over LEN and payload bytes matches.
// Ports:
//   clk    single clock
//   reset  synchronous, active-high
//   bus    imem_boot_loader_if.slave (stream in, imem write, status out)
// Optional feature: define LOADER_TIMEOUT_EN to abort a frame that stalls
// for TIMEOUT_CYCLES consecutive cycles after MAGIC.
module imem_boot_loader #(
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter logic [31:0] ADDR_STEP      = 32'd1,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4,
        RUN   = 3'd5,
        ERROR = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [23:0] lane_q, lane_d;
    logic [31:0] addr_q, addr_d;

    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        rx_ready_q, rx_ready_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        load_done_q, load_done_d;
    logic        load_error_q, load_error_d;

    logic        fire;
    logic [15:0] len_full;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    // rx_ready is a register, so the handshake never depends combinationally on rx_valid.
    assign fire     = bus.rx_valid & rx_ready_q;
    assign len_full = {bus.rx_data, len_q[7:0]};

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= 16'h0;
            cnt_q        <= 16'h0;
            idx_q        <= 2'd0;
            csum_q       <= 8'h0;
            lane_q       <= 24'h0;
            addr_q       <= BASE_ADDR;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            wr_data_q    <= 32'h0;
            rx_ready_q   <= 1'b1;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            lane_q       <= lane_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rx_ready_q   <= rx_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // Idle-gap counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef LOADER_TIMEOUT_EN
        gap_d     = '0;
`endif

        case (state_q)
            IDLE: begin
                // Non-MAGIC bytes are accepted and dropped.
                if (fire && (bus.rx_data == MAGIC)) begin
                    state_d = LEN0;
                    csum_d  = 8'h0;
                    cnt_d   = 16'h0;
                    idx_d   = 2'd0;
                    addr_d  = BASE_ADDR;
                end
            end
            LEN0: begin
                if (fire) begin
                    len_d   = {8'h00, bus.rx_data};
                    csum_d  = csum_q ^ bus.rx_data;
                    state_d = LEN1;
                end
            end
            LEN1: begin
                if (fire) begin
                    len_d  = len_full;
                    csum_d = csum_q ^ bus.rx_data;
                    idx_d  = 2'd0;
                    cnt_d  = 16'h0;
                    if (len_full == 16'h0) begin
                        state_d = CSUM;
                    end else if (32'(len_full) > MAX_WORDS) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (fire) begin
                    csum_d = csum_q ^ bus.rx_data;
                    idx_d  = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: lane_d[7:0]   = bus.rx_data;
                        2'd1: lane_d[15:8]  = bus.rx_data;
                        2'd2: lane_d[23:16] = bus.rx_data;
                        default: begin
                            // Only a complete word is ever written.
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = {bus.rx_data, lane_q};
                            addr_d    = addr_q + ADDR_STEP;
                            cnt_d     = cnt_q + 16'd1;
                            if (cnt_q == (len_q - 16'd1)) begin
                                state_d = CSUM;
                            end
                        end
                    endcase
                end
            end
            CSUM: begin
                if (fire) begin
                    state_d = (csum_q == bus.rx_data) ? RUN : ERROR;
                end
            end
            RUN:     state_d = RUN;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase

`ifdef LOADER_TIMEOUT_EN
        // Counts consecutive byte-less cycles once a frame has started.
        if ((state_q == LEN0) || (state_q == LEN1) ||
            (state_q == DATA) || (state_q == CSUM)) begin
            if (fire) begin
                gap_d = '0;
            end else if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = ERROR;
                gap_d   = '0;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end
`endif

        // Status outputs follow the next state so they change with the transition edge.
        rx_ready_d   = (state_d != RUN) && (state_d != ERROR);
        cpu_reset_d  = (state_d != RUN);
        load_done_d  = (state_d == RUN);
        load_error_d = (state_d == ERROR);
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.imem_wr_en   = wr_en_q;
    assign bus.imem_wr_addr = wr_addr_q;
    assign bus.imem_wr_data = wr_data_q;
    assign bus.cpu_reset    = cpu_reset_q;
    assign bus.load_done    = load_done_q;
    assign bus.load_error   = load_error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames, expected imem
// writes queued at stimulus time and checked by a monitor on every write.
module tb_imem_boot_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    imem_boot_loader_if bus();

`ifdef LOADER_TIMEOUT_EN
    imem_boot_loader #(.MAX_WORDS(1024), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`else
    imem_boot_loader #(.MAX_WORDS(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one byte; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 64; i++) begin
            if (bus.rx_ready === 1'b1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL rx_accept: byte %h not accepted within 64 cycles", b);
        end
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i]);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"},   32'(bus.rx_ready),   32'd1);
        check({tag, "_wr_en"},      32'(bus.imem_wr_en), 32'd0);
        check({tag, "_wr_addr"},    bus.imem_wr_addr,    32'h0);
        check({tag, "_wr_data"},    bus.imem_wr_data,    32'h0);
        check({tag, "_cpu_reset"},  32'(bus.cpu_reset),  32'd1);
        check({tag, "_load_done"},  32'(bus.load_done),  32'd0);
        check({tag, "_load_error"}, 32'(bus.load_error), 32'd0);
    endtask

    task automatic expect_status(input string tag, input logic done, input logic err);
        repeat (2) @(negedge clk);
        check({tag, "_load_done"},  32'(bus.load_done),  32'(done));
        check({tag, "_load_error"}, 32'(bus.load_error), 32'(err));
        check({tag, "_cpu_reset"},  32'(bus.cpu_reset),  32'(!done));
        check({tag, "_rx_ready"},   32'(bus.rx_ready),   32'(!(done || err)));
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    initial begin
        logic [7:0] s[$];
        logic [7:0] cs;
        logic [31:0] w;

        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Write monitor: every strobe must match the queue head, with the core still held.
        fork
            begin
                wr_t got;
                forever begin
                    @(negedge clk);
                    if (bus.imem_wr_en === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_write: addr %h data %h with none expected",
                                     bus.imem_wr_addr, bus.imem_wr_data);
                        end else begin
                            got = exp_q.pop_front();
                            check("wr_addr", bus.imem_wr_addr, got.addr);
                            check("wr_data", bus.imem_wr_data, got.data);
                        end
                        check("cpu_reset_during_write", 32'(bus.cpu_reset), 32'd1);
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_vals("por");

        // Frame 1; checksum 02^00^11^22^33^44^55^66^77^88 = 8A.
        push_wr(32'd0, 32'h44332211);
        push_wr(32'd1, 32'h88776655);
        s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
        send_seq(s);
        expect_status("frame1", 1'b1, 1'b0);

        // Bad checksum: words still land, core stays in reset.
        do_reset();
        push_wr(32'd0, 32'h44332211);
        push_wr(32'd1, 32'h88776655);
        s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h0B};
        send_seq(s);
        expect_status("badcsum", 1'b0, 1'b1);

        // Leading junk then an empty frame.
        do_reset();
        s = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(s);
        expect_status("len0", 1'b1, 1'b0);

        // LEN = 0x0401 exceeds MAX_WORDS.
        do_reset();
        s = '{8'hA5, 8'h01, 8'h04};
        send_seq(s);
        expect_status("overlen", 1'b0, 1'b1);

        // LEN = MAX_WORDS exactly is legal.
        do_reset();
        s = '{8'hA5, 8'h00, 8'h04};
        cs = 8'h00 ^ 8'h04;
        for (int i = 0; i < 1024; i++) begin
            w = {~16'(i), 16'(i)};
            push_wr(32'(i), w);
            for (int k = 0; k < 4; k++) begin
                s.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
        end
        s.push_back(cs);
        send_seq(s);
        expect_status("maxlen", 1'b1, 1'b0);

        // Reset after two payload bytes drops the partial word.
        do_reset();
        s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
        send_seq(s);
        @(negedge clk);
        do_reset();
        check_reset_vals("midreset");
        push_wr(32'd0, 32'h44332211);
        push_wr(32'd1, 32'h88776655);
        s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
        send_seq(s);
        expect_status("resend", 1'b1, 1'b0);

`ifdef LOADER_TIMEOUT_EN
        // Stall after LEN_LO: error on the 16th idle cycle, not before.
        do_reset();
        s = '{8'hA5, 8'h02};
        send_seq(s);
        repeat (15) @(negedge clk);
        check("timeout_early", 32'(bus.load_error), 32'd0);
        @(negedge clk);
        check("timeout_fire", 32'(bus.load_error), 32'd1);
        expect_status("timeout", 1'b0, 1'b1);
`else
        // Mid-frame stall is tolerated; checksum 01^00^DE^AD^BE^EF = 23.
        do_reset();
        push_wr(32'd0, 32'hEFBEADDE);
        s = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD};
        send_seq(s);
        repeat (200) @(negedge clk);
        check("stall_error", 32'(bus.load_error), 32'd0);
        check("stall_ready", 32'(bus.rx_ready),   32'd1);
        s = '{8'hBE, 8'hEF, 8'h23};
        send_seq(s);
        expect_status("stall", 1'b1, 1'b0);
`endif

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
